uart_program_loader: RTL
========================

Name: uart_program_loader

Overview:
- Upstream feeder of the processor's program memory (text RAM) write port; drives its write strobe, write address and 12-bit data word.
- Receives a framed program image over a UART RX line (8N1) and unpacks 12-bit instruction words. Each word is {opcode[3:0], address[7:0]}.
- Holds the processor core in reset (cpu_hold) while a load is in progress and after a failed load.
- Contains one UART receiver sub-module plus a framing and checksum FSM.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, UART bit rate.
- ADDR_WIDTH, 8, program memory address width.
- INSTRUCTION_WIDTH, 4, opcode width.
- DATA_WIDTH, ADDR_WIDTH + INSTRUCTION_WIDTH, program word width. Must be 9..16.
- TIMEOUT_CYCLES, 16 * CLK_FREQ / BAUD * 10, maximum idle gap between bytes inside a frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART serial input; idles high.
- program_write  out  1  one-cycle write strobe to program memory.
- program_address  out  ADDR_WIDTH  write address; valid when program_write=1.
- program_cmd  out  DATA_WIDTH  write data; valid when program_write=1.
- cpu_hold  out  1  1 = keep processor core in reset.
- load_done  out  1  level; last frame completed with a good checksum.
- load_error  out  1  level; last frame aborted or failed its checksum.

Behaviour:
- Reset: FSM goes to IDLE; word address = 0; checksum = 0. All outputs are 0, including cpu_hold.
- uart_rx sub-module:
  - rx passes through a 2-flop synchronizer.
  - CLKS_PER_BIT = CLK_FREQ / BAUD (integer division).
  - Start bit: detected on a falling edge, then re-checked low at half a bit period; if high, treat as a glitch and return to idle.
  - 8 data bits, LSB first, each sampled at mid-bit. Stop bit sampled at mid-bit.
  - Stop bit = 1: pulse byte_valid for 1 cycle with byte_data.
  - Stop bit = 0: pulse frame_err for 1 cycle; no byte_valid.
- Frame format: 0xA5 sync, N, then N words as HI,LO byte pairs, then CHK.
  - N = 0 means 2^ADDR_WIDTH words.
  - HI = {zeros, word[DATA_WIDTH-1:8]}; LO = word[7:0].
  - CHK = XOR of every byte after the sync byte (N, all HI and LO bytes).
- FSM states: IDLE, COUNT, HI, LO, WRITE, CHECK.
  - IDLE: bytes other than 0xA5 and frame_err pulses are ignored. On 0xA5: clear load_done and load_error, set cpu_hold=1, clear the checksum, set address=0, go to COUNT.
  - COUNT: latch N into the remaining-words counter, XOR into the checksum, go to HI.
  - HI: any bit above DATA_WIDTH-9 set → error. Otherwise latch the byte and go to LO.
  - LO: assemble the word and go to WRITE.
  - WRITE: exactly 1 cycle. program_write=1, program_address=current address, program_cmd=word. Then increment the address (wraps mod 2^ADDR_WIDTH) and decrement the remaining count. Go to CHECK if the count reaches 0, else HI.
  - CHECK: CHK equal to the checksum → load_done=1, cpu_hold=0, go to IDLE. Mismatch → error.
- Error action: load_error=1 and go to IDLE. cpu_hold stays 1 until a later load succeeds or reset, so the core never runs a partially written image.
- Latency: program_write asserts 1 cycle after the LO byte_valid pulse. cpu_hold falls 1 cycle after the CHK byte_valid pulse.
- Timeout: in COUNT, HI, LO or CHECK, a byte-gap counter reloads on every byte_valid. If it reaches TIMEOUT_CYCLES → error.
- frame_err in any state other than IDLE → error.
- A 0xA5 byte inside a frame is treated as data, not as a new sync.
- Outside WRITE: program_write=0. program_address and program_cmd hold their last values.
- Reset mid-frame: immediate return to the reset state. cpu_hold=0 (the power-up image is assumed valid).

Decomposition:
- Shared package loader_pkg holds:
  - loader_state_t enum: IDLE, COUNT, HI, LO, WRITE, CHECK.
  - SYNC_BYTE = 8'hA5.
- One sub-module: uart_rx.
  - Parameter CLKS_PER_BIT.
  - Ports: clk, reset, rx, byte_valid, byte_data[7:0], frame_err.

Test Plan:
- Use CLK_FREQ=16, BAUD=1 in all tests.
- Good load: send A5 02 0C 12 03 45 5A → program_write pulses twice: (addr 0, cmd 0xC12) then (addr 1, cmd 0x345). cpu_hold high from A5 until after 5A; then load_done=1, load_error=0.
- Bad checksum: same frame with CHK=5B → both writes occur, load_error=1, load_done=0, cpu_hold stays 1. A following good frame clears the error and drops cpu_hold.
- Illegal HI: send A5 01 1C → load_error=1 right after the 1C byte; no program_write.
- Noise and framing: send bytes 00 FF and a frame with stop bit=0 while IDLE → no output change. The same framing error after A5 → load_error=1.
- Timeout: send A5 01 0C, then silence for TIMEOUT_CYCLES+1 cycles → load_error=1, FSM back in IDLE.
- Reset mid-frame: assert reset after A5 02 0C → next cycle all outputs are 0. A fresh good frame then writes starting at addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  // Framing FSM states of the loader
  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    WRITE,
    CHECK
  } loader_state_t;

  // Bit-level states of the UART receiver
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // A HI byte may only carry the word bits that sit above bit 7.
  function automatic logic hi_byte_legal(input logic [7:0] b, input int data_width);
    return (b >> (data_width - 8)) == 8'd0;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, glitch-filtered
// start bit, one-cycle byte_valid or frame_err pulse per character.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half-bit wait, start bit re-checked low
// RX_DATA  | sampling 8 data bits LSB first at mid-bit
// RX_STOP  | sampling the stop bit at mid-bit
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;

  // Synchronise rx, then walk start/data/stop with a mid-bit down-counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rx_sync) begin
            state   <= RX_DATA;
            cnt     <= BIT_LOAD;
            bit_idx <= '0;
          end else begin
            // start bit did not hold low for half a bit: glitch
            state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift <= {rx_sync, shift[7:1]};
            cnt   <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a framed program image from a UART line into the program memory
// write port, holding the core in reset until a complete image with a good
// checksum has been written.
//
// state | meaning
// IDLE  | waiting for the sync byte; other bytes and framing errors ignored
// COUNT | next byte is the word count N (0 = full memory)
// HI    | next byte is the upper part of a word
// LO    | next byte is the lower 8 bits of a word
// WRITE | one-cycle program memory write, advance address and count
// CHECK | next byte is the XOR checksum
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ          = 50_000_000,
  parameter int BAUD              = 115_200,
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int TIMEOUT_CYCLES    = 16 * CLK_FREQ / BAUD * 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  program_write,
  output logic [ADDR_WIDTH-1:0] program_address,
  output logic [DATA_WIDTH-1:0] program_cmd,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  // DATA_WIDTH is expected to lie in 9..16 so a word always splits into a
  // non-empty HI part plus a full LO byte.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HI_W         = DATA_WIDTH - 8;
  localparam int GAP_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int REM_W        = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(2 ** ADDR_WIDTH);

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  frame_err;

  loader_state_t         state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REM_W-1:0]      remaining;
  logic [7:0]            checksum;
  logic [HI_W-1:0]       hi_part;
  logic [GAP_W-1:0]      gap_cnt;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Framing FSM with byte-gap timeout, checksum and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      addr            <= '0;
      remaining       <= '0;
      checksum        <= '0;
      hi_part         <= '0;
      gap_cnt         <= '0;
      program_write   <= 1'b0;
      program_address <= '0;
      program_cmd     <= '0;
      cpu_hold        <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
    end else begin
      program_write <= 1'b0;

      // gap timer is frozen during the single WRITE cycle
      if (state != WRITE) begin
        if (byte_valid) begin
          gap_cnt <= GAP_LOAD;
        end else if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - GAP_W'(1);
        end
      end

      if (state != IDLE && frame_err) begin
        load_error <= 1'b1;
        state      <= IDLE;
      end else if (state != IDLE && state != WRITE && !byte_valid && gap_cnt == '0) begin
        load_error <= 1'b1;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (byte_valid && byte_data == SYNC_BYTE) begin
              load_done  <= 1'b0;
              load_error <= 1'b0;
              cpu_hold   <= 1'b1;
              checksum   <= '0;
              addr       <= '0;
              state      <= COUNT;
            end
          end
          COUNT: begin
            if (byte_valid) begin
              remaining <= (byte_data == 8'd0) ? REM_FULL : REM_W'(byte_data);
              checksum  <= checksum ^ byte_data;
              state     <= HI;
            end
          end
          HI: begin
            if (byte_valid) begin
              if (!hi_byte_legal(byte_data, DATA_WIDTH)) begin
                load_error <= 1'b1;
                state      <= IDLE;
              end else begin
                hi_part  <= byte_data[HI_W-1:0];
                checksum <= checksum ^ byte_data;
                state    <= LO;
              end
            end
          end
          LO: begin
            if (byte_valid) begin
              checksum        <= checksum ^ byte_data;
              program_write   <= 1'b1;
              program_address <= addr;
              program_cmd     <= {hi_part, byte_data};
              state           <= WRITE;
            end
          end
          WRITE: begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - REM_W'(1);
            state     <= (remaining == REM_W'(1)) ? CHECK : HI;
          end
          CHECK: begin
            if (byte_valid) begin
              if (byte_data == checksum) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
              end else begin
                // cpu_hold stays set so a partial image never runs
                load_error <= 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
